// File: rtl/out_sched_pkg.sv
// Shared types and constants for the output-port scheduler.
package out_sched_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      HOLD  = 2'd2
   } state_t;

   localparam logic SRC_CPU = 1'b0;
   localparam logic SRC_DBG = 1'b1;

   localparam int unsigned DEF_WIDTH       = 16;
   localparam int unsigned DEF_HOLD_CYCLES = 4;
   localparam int unsigned DEF_CNT_W       = 8;

endpackage

// File: rtl/out_sched_if.sv
// Requester handshakes and output-register side of the output-port scheduler.
interface out_sched_if
   import out_sched_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned CNT_W = DEF_CNT_W
);
   logic             cpu_valid;
   logic [WIDTH-1:0] cpu_data;
   logic             cpu_ready;
   logic             dbg_valid;
   logic [WIDTH-1:0] dbg_data;
   logic             dbg_ready;
   logic             out_write;
   logic [WIDTH-1:0] out_data;
   logic             busy;
   logic             last_src;
   logic [CNT_W-1:0] write_count;

   // Requester / observer side.
   modport master (
      output cpu_valid, cpu_data, dbg_valid, dbg_data,
      input  cpu_ready, dbg_ready, out_write, out_data, busy, last_src, write_count
   );

   // Scheduler side.
   modport slave (
      input  cpu_valid, cpu_data, dbg_valid, dbg_data,
      output cpu_ready, dbg_ready, out_write, out_data, busy, last_src, write_count
   );
endinterface

// File: rtl/out_sched_rr_arb.sv
// Combinational 2-way arbiter: grant[0] = CPU, grant[1] = debug.
// OUT_SCHED_CPU_PRIO_EN selects fixed CPU priority instead of round-robin.
module out_sched_rr_arb
   import out_sched_pkg::*;
(
   input  logic       cpu_valid,
   input  logic       dbg_valid,
   input  logic       last_src,
   output logic [1:0] grant
);

   // Pick the winner among the valid requesters.
   always_comb begin
      grant = '0;
`ifdef OUT_SCHED_CPU_PRIO_EN
      if (cpu_valid)
         grant = 2'b01;
      else if (dbg_valid)
         grant = 2'b10;
`else
      if (cpu_valid && dbg_valid)
         grant = (last_src == SRC_CPU) ? 2'b10 : 2'b01;
      else if (cpu_valid)
         grant = 2'b01;
      else if (dbg_valid)
         grant = 2'b10;
`endif
   end

endmodule

// File: rtl/out_sched.sv
// Output-port scheduler: shares the output register between the CPU OUT path
// and the debug port, with a minimum display hold after every write.
// Optional macro OUT_SCHED_CPU_PRIO_EN: CPU always wins contention.
module out_sched
   import out_sched_pkg::*;
#(
   parameter int unsigned WIDTH       = DEF_WIDTH,
   parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES,
   parameter int unsigned CNT_W       = DEF_CNT_W
)(
   input  logic      clk,
   input  logic      rst,
   out_sched_if.slave bus
);

   state_t           state, state_next;
   logic [CNT_W-1:0] hold_cnt;
   logic [CNT_W-1:0] write_count;
   logic [WIDTH-1:0] out_data;
   logic             last_src;
   logic [1:0]       grant;
   logic             xfer;

   out_sched_rr_arb u_arb (
      .cpu_valid (bus.cpu_valid),
      .dbg_valid (bus.dbg_valid),
      .last_src  (last_src),
      .grant     (grant)
   );

   assign xfer = (bus.cpu_valid && bus.cpu_ready) || (bus.dbg_valid && bus.dbg_ready);

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state <= IDLE;
      else
         state <= state_next;
   end

   // Next-state logic.
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (xfer) state_next = WRITE;
         WRITE:   state_next = (HOLD_CYCLES == 0) ? IDLE : HOLD;
         HOLD:    if (hold_cnt <= CNT_W'(1)) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Outputs decoded from state; readys only offered in IDLE.
   always_comb begin
      bus.cpu_ready   = (state == IDLE) && grant[0];
      bus.dbg_ready   = (state == IDLE) && grant[1];
      bus.out_write   = (state == WRITE);
      bus.busy        = (state != IDLE);
      bus.out_data    = out_data;
      bus.last_src    = last_src;
      bus.write_count = write_count;
   end

   // Data register, winner history, hold counter and write counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_data    <= '0;
         last_src    <= SRC_DBG;
         hold_cnt    <= '0;
         write_count <= '0;
      end else begin
         unique case (state)
            IDLE: if (xfer) begin
               out_data <= grant[1] ? bus.dbg_data : bus.cpu_data;
               last_src <= grant[1] ? SRC_DBG : SRC_CPU;
            end
            WRITE: begin
               write_count <= write_count + CNT_W'(1);
               hold_cnt    <= CNT_W'(HOLD_CYCLES);
            end
            HOLD:    hold_cnt <= hold_cnt - CNT_W'(1);
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_out_sched.sv
// Self-checking bench for out_sched: HOLD_CYCLES=4 instance for handshake,
// contention, hold and reset scenarios; HOLD_CYCLES=0 instance for wrap.
module tb_out_sched;
   import out_sched_pkg::*;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   logic [15:0] q_a[$];
   logic [15:0] q_b[$];

   out_sched_if #(.WIDTH(16), .CNT_W(8)) bus_a ();
   out_sched_if #(.WIDTH(16), .CNT_W(8)) bus_b ();

   out_sched #(.WIDTH(16), .HOLD_CYCLES(4), .CNT_W(8)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (bus_a.slave)
   );

   out_sched #(.WIDTH(16), .HOLD_CYCLES(0), .CNT_W(8)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (bus_b.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   // Scoreboard: every strobe pops the expected value.
   always @(negedge clk) begin
      logic [15:0] e;
      if (rst && bus_a.out_write) begin
         checks++;
         if (q_a.size() == 0) begin
            errors++;
            $display("FAIL write_a_unexpected: out_data=%h, required no write", bus_a.out_data);
         end else begin
            e = q_a.pop_front();
            if (bus_a.out_data !== e) begin
               errors++;
               $display("FAIL write_a_data: out_data=%h, required %h", bus_a.out_data, e);
            end
         end
      end
      if (rst && bus_b.out_write) begin
         checks++;
         if (q_b.size() == 0) begin
            errors++;
            $display("FAIL write_b_unexpected: out_data=%h, required no write", bus_b.out_data);
         end else begin
            e = q_b.pop_front();
            if (bus_b.out_data !== e) begin
               errors++;
               $display("FAIL write_b_data: out_data=%h, required %h", bus_b.out_data, e);
            end
         end
      end
   end

   task automatic wait_idle_a();
      int n;
      n = 0;
      while (bus_a.busy && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (bus_a.busy !== 1'b0) begin
         errors++;
         $display("FAIL idle_timeout: busy=%b, required 0", bus_a.busy);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      bus_a.cpu_valid = 1'b0; bus_a.dbg_valid = 1'b0;
      bus_a.cpu_data = '0;    bus_a.dbg_data = '0;
      bus_b.cpu_valid = 1'b0; bus_b.dbg_valid = 1'b0;
      bus_b.cpu_data = '0;    bus_b.dbg_data = '0;
      #8;
      checks += 7;
      if (bus_a.out_write !== 1'b0) begin errors++; $display("FAIL rst_out_write: got %b, required 0", bus_a.out_write); end
      if (bus_a.out_data !== 16'h0) begin errors++; $display("FAIL rst_out_data: got %h, required 0000", bus_a.out_data); end
      if (bus_a.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b, required 0", bus_a.busy); end
      if (bus_a.write_count !== 8'h0) begin errors++; $display("FAIL rst_write_count: got %0d, required 0", bus_a.write_count); end
      if (bus_a.last_src !== 1'b1) begin errors++; $display("FAIL rst_last_src: got %b, required 1", bus_a.last_src); end
      if (bus_a.cpu_ready !== 1'b0) begin errors++; $display("FAIL rst_cpu_ready: got %b, required 0", bus_a.cpu_ready); end
      if (bus_a.dbg_ready !== 1'b0) begin errors++; $display("FAIL rst_dbg_ready: got %b, required 0", bus_a.dbg_ready); end
      #4 rst = 1'b1;
   endtask

   task automatic test_single();
      @(posedge clk); #1;
      bus_a.cpu_valid = 1'b1;
      bus_a.cpu_data  = 16'd74;
      q_a.push_back(16'd74);
      #1;
      checks += 3;
      if (bus_a.cpu_ready !== 1'b1) begin errors++; $display("FAIL single_cpu_ready: got %b, required 1", bus_a.cpu_ready); end
      if (bus_a.dbg_ready !== 1'b0) begin errors++; $display("FAIL single_dbg_ready: got %b, required 0", bus_a.dbg_ready); end
      if (bus_a.busy !== 1'b0) begin errors++; $display("FAIL single_busy_idle: got %b, required 0", bus_a.busy); end
      @(posedge clk); #1;
      bus_a.cpu_valid = 1'b0;
      checks += 3;
      if (bus_a.out_write !== 1'b1) begin errors++; $display("FAIL single_strobe: got %b, required 1", bus_a.out_write); end
      if (bus_a.out_data !== 16'd74) begin errors++; $display("FAIL single_out_data: got %0d, required 74", bus_a.out_data); end
      if (bus_a.busy !== 1'b1) begin errors++; $display("FAIL single_busy_write: got %b, required 1", bus_a.busy); end
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         checks += 2;
         if (bus_a.out_write !== 1'b0) begin errors++; $display("FAIL single_hold_strobe[%0d]: got %b, required 0", i, bus_a.out_write); end
         if (bus_a.busy !== 1'b1) begin errors++; $display("FAIL single_hold_busy[%0d]: got %b, required 1", i, bus_a.busy); end
      end
      @(posedge clk); #1;
      checks += 4;
      if (bus_a.busy !== 1'b0) begin errors++; $display("FAIL single_busy_end: got %b, required 0", bus_a.busy); end
      if (bus_a.write_count !== 8'd1) begin errors++; $display("FAIL single_write_count: got %0d, required 1", bus_a.write_count); end
      if (bus_a.last_src !== SRC_CPU) begin errors++; $display("FAIL single_last_src: got %b, required 0", bus_a.last_src); end
      if (bus_a.out_data !== 16'd74) begin errors++; $display("FAIL single_data_kept: got %0d, required 74", bus_a.out_data); end
   endtask

   task automatic test_contention();
      int cyc, prev, n;
      @(posedge clk); #1;
      rst = 1'b0;
      #2 rst = 1'b1;
      bus_a.cpu_data  = 16'h1111;
      bus_a.dbg_data  = 16'h2222;
      bus_a.cpu_valid = 1'b1;
      bus_a.dbg_valid = 1'b1;
`ifdef OUT_SCHED_CPU_PRIO_EN
      for (int i = 0; i < 4; i++) q_a.push_back(16'h1111);
`else
      for (int i = 0; i < 4; i++) q_a.push_back((i % 2 == 0) ? 16'h1111 : 16'h2222);
`endif
      cyc = 0; prev = -1; n = 0;
      while (n < 4 && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
         checks++;
`ifdef OUT_SCHED_CPU_PRIO_EN
         if (bus_a.dbg_ready !== 1'b0) begin errors++; $display("FAIL prio_dbg_ready: got %b, required 0 while cpu_valid", bus_a.dbg_ready); end
`else
         if (bus_a.cpu_ready && bus_a.dbg_ready) begin errors++; $display("FAIL contention_both_ready: got 11, required at most one"); end
`endif
         if (bus_a.out_write) begin
            if (prev >= 0) begin
               checks++;
               if (cyc - prev != 6) begin errors++; $display("FAIL contention_spacing: got %0d, required 6", cyc - prev); end
            end
            prev = cyc;
            n++;
         end
      end
      checks++;
      if (n != 4) begin errors++; $display("FAIL contention_timeout: got %0d writes, required 4", n); end
      bus_a.cpu_valid = 1'b0;
      bus_a.dbg_valid = 1'b0;
      wait_idle_a();
      checks++;
      if (bus_a.write_count !== 8'd4) begin errors++; $display("FAIL contention_count: got %0d, required 4", bus_a.write_count); end
   endtask

   task automatic test_hold();
      int k;
      @(posedge clk); #1;
      bus_a.cpu_valid = 1'b1;
      bus_a.cpu_data  = 16'hABCD;
      q_a.push_back(16'hABCD);
      @(posedge clk); #1;
      bus_a.cpu_valid = 1'b0;
      @(posedge clk); #1;
      bus_a.dbg_valid = 1'b1;
      bus_a.dbg_data  = 16'h5A5A;
      #1;
      k = 0;
      while (bus_a.busy && k < 12) begin
         checks += 2;
         if (bus_a.dbg_ready !== 1'b0) begin errors++; $display("FAIL hold_dbg_ready: got %b, required 0", bus_a.dbg_ready); end
         if (bus_a.out_data !== 16'hABCD) begin errors++; $display("FAIL hold_out_data: got %h, required abcd", bus_a.out_data); end
         @(posedge clk); #1;
         k++;
      end
      checks += 2;
      if (k != 4) begin errors++; $display("FAIL hold_length: got %0d cycles, required 4", k); end
      if (bus_a.dbg_ready !== 1'b1) begin errors++; $display("FAIL hold_first_idle_ready: got %b, required 1", bus_a.dbg_ready); end
      q_a.push_back(16'h5A5A);
      @(posedge clk); #1;
      bus_a.dbg_valid = 1'b0;
      wait_idle_a();
      checks++;
      if (bus_a.last_src !== SRC_DBG) begin errors++; $display("FAIL hold_last_src: got %b, required 1", bus_a.last_src); end
   endtask

   task automatic test_reset_mid_hold();
      @(posedge clk); #1;
      bus_a.cpu_valid = 1'b1;
      bus_a.cpu_data  = 16'h0F0F;
      q_a.push_back(16'h0F0F);
      @(posedge clk); #1;
      bus_a.cpu_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      checks++;
      if (bus_a.busy !== 1'b1) begin errors++; $display("FAIL midrst_pre_busy: got %b, required 1", bus_a.busy); end
      #2 rst = 1'b0;
      #1;
      checks += 4;
      if (bus_a.out_data !== 16'h0) begin errors++; $display("FAIL midrst_out_data: got %h, required 0000", bus_a.out_data); end
      if (bus_a.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b, required 0", bus_a.busy); end
      if (bus_a.write_count !== 8'h0) begin errors++; $display("FAIL midrst_write_count: got %0d, required 0", bus_a.write_count); end
      if (bus_a.out_write !== 1'b0) begin errors++; $display("FAIL midrst_out_write: got %b, required 0", bus_a.out_write); end
      #2 rst = 1'b1;
      @(posedge clk); #1;
      bus_a.cpu_valid = 1'b1;
      bus_a.cpu_data  = 16'h1234;
      q_a.push_back(16'h1234);
      #1;
      checks++;
      if (bus_a.cpu_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready_after: got %b, required 1", bus_a.cpu_ready); end
      @(posedge clk); #1;
      bus_a.cpu_valid = 1'b0;
      checks++;
      if (bus_a.out_write !== 1'b1) begin errors++; $display("FAIL midrst_strobe_after: got %b, required 1", bus_a.out_write); end
      wait_idle_a();
      checks++;
      if (bus_a.write_count !== 8'd1) begin errors++; $display("FAIL midrst_count_after: got %0d, required 1", bus_a.write_count); end
   endtask

   task automatic test_back_to_back_wrap();
      int w;
      bool_loop: begin
         @(posedge clk); #1;
         bus_b.cpu_data  = 16'd0;
         bus_b.cpu_valid = 1'b1;
         #1;
         for (int i = 0; i < 256; i++) begin
            w = 0;
            while (!bus_b.cpu_ready && w < 5) begin
               @(posedge clk); #1;
               w++;
            end
            checks++;
            if (bus_b.cpu_ready !== 1'b1) begin
               errors++;
               $display("FAIL wrap_timeout[%0d]: cpu_ready=%b, required 1", i, bus_b.cpu_ready);
               disable bool_loop;
            end
            if (i > 0) begin
               checks++;
               if (w != 1) begin errors++; $display("FAIL wrap_spacing[%0d]: got %0d, required 1 idle wait", i, w); end
            end
            if (i == 255) begin
               checks++;
               if (bus_b.write_count !== 8'd255) begin errors++; $display("FAIL wrap_pre_count: got %0d, required 255", bus_b.write_count); end
            end
            q_b.push_back(16'(i));
            @(posedge clk); #1;
            bus_b.cpu_data = 16'(i + 1);
         end
      end
      bus_b.cpu_valid = 1'b0;
      @(posedge clk); #1;
      checks += 3;
      if (bus_b.write_count !== 8'd0) begin errors++; $display("FAIL wrap_count: got %0d, required 0", bus_b.write_count); end
      if (bus_b.out_data !== 16'd255) begin errors++; $display("FAIL wrap_last_data: got %0d, required 255", bus_b.out_data); end
      if (bus_b.busy !== 1'b0) begin errors++; $display("FAIL wrap_busy: got %b, required 0", bus_b.busy); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_single();
      test_contention();
      test_hold();
      test_reset_mid_hold();
      test_back_to_back_wrap();
      @(posedge clk); #1;
      checks += 2;
      if (q_a.size() != 0) begin errors++; $display("FAIL scoreboard_a_left: got %0d pending, required 0", q_a.size()); end
      if (q_b.size() != 0) begin errors++; $display("FAIL scoreboard_b_left: got %0d pending, required 0", q_b.size()); end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
